target_streamer: RTL

TARGET_STREAMER -- requirements
Module: target_streamer

---
 rtl/target_streamer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/target_streamer.sv
// target_streamer: unpacks 2-bit target bases from 32-bit words into a scoring bank,
// then collects the bank's score, substituting the biased zero if the bank never answers.
module target_streamer #(
    parameter int SCORE_WIDTH = 12,
    parameter int LENGTH      = 128,
    parameter int LOG_LENGTH  = 8,
    parameter int ZERO        = 2**(SCORE_WIDTH-1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [15:0]            tlen,
    input  logic [LOG_LENGTH-1:0]  qlen,
    input  logic [31:0]            word_in,
    input  logic                   word_valid,
    output logic                   word_ready,
    output logic [1:0]             data_out,
    output logic                   en_out,
    output logic [LOG_LENGTH-1:0]  counter_out,
    input  logic [SCORE_WIDTH-1:0] result_in,
    input  logic                   vld_in,
    output logic [SCORE_WIDTH-1:0] score_out,
    output logic                   score_valid,
    input  logic                   score_ready,
    output logic                   busy,
    output logic                   err
);
    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, DRAIN, DONE} state_t;

    localparam logic [SCORE_WIDTH-1:0] ZERO_SCORE = SCORE_WIDTH'(ZERO);
    localparam logic [8:0]             DRAIN_LAST = 9'(LENGTH + 3);

    state_t                 state_q, state_d;
    logic [15:0]            rem_q, rem_d;
    logic [29:0]            sh_q, sh_d;
    logic [3:0]             left_q, left_d;
    logic [8:0]             drain_q, drain_d;
    logic [1:0]             data_q, data_d;
    logic                   en_q, en_d;
    logic [LOG_LENGTH-1:0]  cnt_q, cnt_d;
    logic [SCORE_WIDTH-1:0] score_q, score_d;
    logic                   err_q, err_d;
    logic                   pulse_q, pulse_d;
    logic                   xfer;

    // Accept the next word while its predecessor's last base is on the wire so words stream gap-free.
    assign word_ready  = state_q == FETCH || (state_q == SHIFT && left_q == 4'd0 && rem_q != 16'd0);
    assign xfer        = word_valid && word_ready;
    assign data_out    = data_q;
    assign en_out      = en_q;
    assign counter_out = cnt_q;
    assign score_out   = score_q;
    assign score_valid = state_q == DONE;
    assign busy        = state_q != IDLE;
    assign err         = err_q | pulse_q;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        left_d  = left_q;
        drain_d = drain_q;
        data_d  = data_q;
        en_d    = 1'b0;
        cnt_d   = cnt_q;
        score_d = score_q;
        err_d   = err_q;
        pulse_d = 1'b0;
        if (xfer) begin
            state_d = SHIFT;
            data_d  = word_in[1:0];
            en_d    = 1'b1;
            sh_d    = word_in[31:2];
            left_d  = rem_q >= 16'd16 ? 4'd15 : rem_q[3:0] - 4'd1;
            rem_d   = rem_q - 16'd1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && tlen == 16'd0) begin
                        pulse_d = 1'b1;
                    end else if (start) begin
                        state_d = FETCH;
                        rem_d   = tlen;
                        cnt_d   = qlen;
                        err_d   = 1'b0;
                    end
                end
                SHIFT: begin
                    if (left_q != 4'd0) begin
                        data_d = sh_q[1:0];
                        en_d   = 1'b1;
                        sh_d   = sh_q >> 2;
                        left_d = left_q - 4'd1;
                        rem_d  = rem_q - 16'd1;
                    end else if (rem_q != 16'd0) begin
                        state_d = FETCH;
                    end else begin
                        state_d = DRAIN;
                        drain_d = 9'd0;
                    end
                end
                DRAIN: begin
                    if (vld_in) begin
                        score_d = result_in;
                        state_d = DONE;
                    end else if (drain_q == DRAIN_LAST) begin
                        score_d = ZERO_SCORE;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        drain_d = drain_q + 9'd1;
                    end
                end
                DONE: state_d = score_ready ? IDLE : DONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            sh_q    <= '0;
            left_q  <= '0;
            drain_q <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            cnt_q   <= '0;
            score_q <= ZERO_SCORE;
            err_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
            left_q  <= left_d;
            drain_q <= drain_d;
            data_q  <= data_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
            score_q <= score_d;
            err_q   <= err_d;
            pulse_q <= pulse_d;
        end
    end
endmodule
